// File: rtl/wb_ram_arbiter.sv
// Two-port Wishbone to single-port RAM arbiter; tie-break round-robin when WB_RAM_ARB_ROUND_ROBIN_EN is defined, port A priority otherwise.
// Latency: request sampled in IDLE -> chip select low next cycle -> ack the cycle after (3 cycles per transaction).
// Backpressure: the losing port is stalled by withholding its ack until it is granted.
module wb_ram_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,

  input  logic                  wbs_a_stb_i,
  input  logic                  wbs_a_cyc_i,
  input  logic                  wbs_a_we_i,
  input  logic [3:0]            wbs_a_sel_i,
  input  logic [31:0]           wbs_a_adr_i,
  input  logic [31:0]           wbs_a_dat_i,
  output logic [31:0]           wbs_a_dat_o,
  output logic                  wbs_a_ack_o,

  input  logic                  wbs_b_stb_i,
  input  logic                  wbs_b_cyc_i,
  input  logic                  wbs_b_we_i,
  input  logic [3:0]            wbs_b_sel_i,
  input  logic [31:0]           wbs_b_adr_i,
  input  logic [31:0]           wbs_b_dat_i,
  output logic [31:0]           wbs_b_dat_o,
  output logic                  wbs_b_ack_o,

  output logic                  ram_csb,
  output logic                  ram_web,
  output logic [3:0]            ram_wmask,
  output logic [ADDR_WIDTH-3:0] ram_addr,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  localparam logic [31:0] WIN_MASK = ~((32'h1 << ADDR_WIDTH) - 32'h1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic                  req_a, req_b;
  logic                  grant_b_d, grant_b_q;
  logic                  load;
  logic                  gnt_cyc;
  logic                  resp_live;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic                  web_q;
  logic [3:0]            wmask_q;
  logic [31:0]           din_q;

  assign req_a = wbs_a_stb_i & wbs_a_cyc_i & ((wbs_a_adr_i & WIN_MASK) == BASE_ADDR);
  assign req_b = wbs_b_stb_i & wbs_b_cyc_i & ((wbs_b_adr_i & WIN_MASK) == BASE_ADDR);

`ifdef WB_RAM_ARB_ROUND_ROBIN_EN
  // Remembers which port won most recently; starts at B so A takes the first tie.
  logic last_b_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      last_b_q <= 1'b1;
    end else if (load) begin
      last_b_q <= grant_b_d;
    end
  end

  always_comb begin
    grant_b_d = req_b & (~req_a | ~last_b_q);
  end
`else
  always_comb begin
    grant_b_d = ~req_a;
  end
`endif

  assign gnt_cyc = grant_b_q ? wbs_b_cyc_i : wbs_a_cyc_i;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a | req_b) begin
          state_d = ACCESS;
          load    = 1'b1;
        end
      end
      // The strobe has already happened, so an abandoned cycle skips straight back.
      ACCESS:  state_d = gnt_cyc ? RESP : IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      grant_b_q <= 1'b0;
      addr_q    <= '0;
      web_q     <= 1'b1;
      wmask_q   <= 4'h0;
      din_q     <= 32'h0;
    end else begin
      state_q <= state_d;
      if (load) begin
        grant_b_q <= grant_b_d;
        if (grant_b_d) begin
          addr_q  <= wbs_b_adr_i[ADDR_WIDTH-1:2];
          web_q   <= ~wbs_b_we_i;
          wmask_q <= wbs_b_we_i ? wbs_b_sel_i : 4'h0;
          din_q   <= wbs_b_dat_i;
        end else begin
          addr_q  <= wbs_a_adr_i[ADDR_WIDTH-1:2];
          web_q   <= ~wbs_a_we_i;
          wmask_q <= wbs_a_we_i ? wbs_a_sel_i : 4'h0;
          din_q   <= wbs_a_dat_i;
        end
      end
    end
  end

  // Reset in flight must neither strobe the macro nor ack the master.
  assign ram_csb   = ~((state_q == ACCESS) & ~wb_rst_i);
  assign ram_web   = ram_csb ? 1'b1 : web_q;
  assign ram_wmask = wmask_q;
  assign ram_addr  = addr_q;
  assign ram_din   = din_q;

  assign resp_live   = (state_q == RESP) & ~wb_rst_i;
  assign wbs_a_ack_o = resp_live & ~grant_b_q & wbs_a_cyc_i;
  assign wbs_b_ack_o = resp_live &  grant_b_q & wbs_b_cyc_i;
  assign wbs_a_dat_o = (resp_live & ~grant_b_q) ? ram_dout : 32'h0;
  assign wbs_b_dat_o = (resp_live &  grant_b_q) ? ram_dout : 32'h0;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: behavioural RAM macro, reference memory and expected grant order.
module tb_wb_ram_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_a_stb_i, wbs_a_cyc_i, wbs_a_we_i;
  logic [3:0]  wbs_a_sel_i;
  logic [31:0] wbs_a_adr_i, wbs_a_dat_i, wbs_a_dat_o;
  logic        wbs_a_ack_o;
  logic        wbs_b_stb_i, wbs_b_cyc_i, wbs_b_we_i;
  logic [3:0]  wbs_b_sel_i;
  logic [31:0] wbs_b_adr_i, wbs_b_dat_i, wbs_b_dat_o;
  logic        wbs_b_ack_o;
  logic        ram_csb, ram_web;
  logic [3:0]  ram_wmask;
  logic [5:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic [31:0] ram_mem [64];
  logic [31:0] ref_mem [64];
  int          n_chk = 0;
  int          n_err = 0;
  int          both_ack_cnt = 0;

  wb_ram_arbiter dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_a_stb_i(wbs_a_stb_i), .wbs_a_cyc_i(wbs_a_cyc_i), .wbs_a_we_i(wbs_a_we_i),
    .wbs_a_sel_i(wbs_a_sel_i), .wbs_a_adr_i(wbs_a_adr_i), .wbs_a_dat_i(wbs_a_dat_i),
    .wbs_a_dat_o(wbs_a_dat_o), .wbs_a_ack_o(wbs_a_ack_o),
    .wbs_b_stb_i(wbs_b_stb_i), .wbs_b_cyc_i(wbs_b_cyc_i), .wbs_b_we_i(wbs_b_we_i),
    .wbs_b_sel_i(wbs_b_sel_i), .wbs_b_adr_i(wbs_b_adr_i), .wbs_b_dat_i(wbs_b_dat_i),
    .wbs_b_dat_o(wbs_b_dat_o), .wbs_b_ack_o(wbs_b_ack_o),
    .ram_csb(ram_csb), .ram_web(ram_web), .ram_wmask(ram_wmask),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Behavioural single-port macro: masked write or registered read on a low chip select.
  always @(posedge wb_clk_i) begin
    if (!ram_csb) begin
      if (!ram_web) begin
        for (int i = 0; i < 4; i++)
          if (ram_wmask[i]) ram_mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
      end else begin
        ram_dout <= ram_mem[ram_addr];
      end
    end
  end

  always @(negedge wb_clk_i) begin
    if (wbs_a_ack_o && wbs_b_ack_o) both_ack_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic get_ack(input int p);
    return (p == 0) ? wbs_a_ack_o : wbs_b_ack_o;
  endfunction

  function automatic logic [31:0] get_dat(input int p);
    return (p == 0) ? wbs_a_dat_o : wbs_b_dat_o;
  endfunction

  task automatic drive(input int p, input logic on, input logic we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] dat);
    if (p == 0) begin
      wbs_a_stb_i = on; wbs_a_cyc_i = on; wbs_a_we_i = we;
      wbs_a_sel_i = sel; wbs_a_adr_i = adr; wbs_a_dat_i = dat;
    end else begin
      wbs_b_stb_i = on; wbs_b_cyc_i = on; wbs_b_we_i = we;
      wbs_b_sel_i = sel; wbs_b_adr_i = adr; wbs_b_dat_i = dat;
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic ref_write(input logic [5:0] wa, input logic [3:0] sel, input logic [31:0] dat);
    for (int i = 0; i < 4; i++)
      if (sel[i]) ref_mem[wa][8*i +: 8] = dat[8*i +: 8];
  endtask

  // One in-window transaction from an idle arbiter; checks strobe, ack timing and read data.
  task automatic do_txn(input int p, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat);
    logic [5:0]  wa;
    logic [31:0] exp_rd;
    wa     = adr[7:2];
    exp_rd = ref_mem[wa];
    drive(p, 1'b1, we, sel, adr, dat);
    tick();
    check("acc_csb", ram_csb, 0);
    check("acc_addr", ram_addr, wa);
    check("acc_web", ram_web, !we);
    check("acc_wmask", ram_wmask, we ? sel : 4'h0);
    if (we) check("acc_din", ram_din, dat);
    check("acc_ack", get_ack(p), 0);
    tick();
    check("resp_csb", ram_csb, 1);
    check("resp_web", ram_web, 1);
    check("resp_ack", get_ack(p), 1);
    check("resp_other_ack", get_ack(1 - p), 0);
    if (!we) check("resp_dat", get_dat(p), exp_rd);
    else ref_write(wa, sel, dat);
    drive(p, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic do_oow(input int p, input logic [31:0] adr);
    int hits;
    hits = 0;
    drive(p, 1'b1, 1'b0, 4'hF, adr, 32'h0);
    repeat (10) begin
      tick();
      if (!ram_csb) hits++;
      if (get_ack(p)) hits++;
    end
    check("oow_quiet", hits, 0);
    drive(p, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic check_reset_vals();
    check("rst_csb", ram_csb, 1);
    check("rst_web", ram_web, 1);
    check("rst_wmask", ram_wmask, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_din", ram_din, 0);
    check("rst_ack_a", wbs_a_ack_o, 0);
    check("rst_ack_b", wbs_b_ack_o, 0);
    check("rst_dat_a", wbs_a_dat_o, 0);
    check("rst_dat_b", wbs_b_dat_o, 0);
  endtask

  task automatic tie_test();
    int   acks;
    int   ack_cyc [4];
    logic ack_who [4];
    logic last_b;
    logic exp_b;
    acks = 0;
    drive(0, 1'b1, 1'b0, 4'hF, 32'h3000_0004, 32'h0);
    drive(1, 1'b1, 1'b0, 4'hF, 32'h3000_0008, 32'h0);
    for (int c = 1; c <= 40 && acks < 4; c++) begin
      tick();
      if (wbs_a_ack_o || wbs_b_ack_o) begin
        ack_cyc[acks] = c;
        ack_who[acks] = wbs_b_ack_o;
        acks++;
      end
    end
    check("tie_count", acks, 4);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    tick();
    // Both ports always request, so each grant is a tie; history starts at B after reset.
    last_b = 1'b1;
    for (int i = 0; i < acks; i++) begin
`ifdef WB_RAM_ARB_ROUND_ROBIN_EN
      exp_b = !last_b;
`else
      exp_b = 1'b0;
`endif
      last_b = exp_b;
      check("tie_grant", ack_who[i], exp_b);
      check("tie_cycle", ack_cyc[i], 2 + 3 * i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          p;
    wb_rst_i = 1'b1;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    repeat (3) tick();
    check_reset_vals();
    wb_rst_i = 1'b0;
    tick();

    do_txn(0, 1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF);
    do_txn(1, 1'b0, 32'h3000_0010, 4'hF, 32'h0);

    for (int w = 0; w < 8; w++)
      if (w != 4) do_txn(w % 2, 1'b1, 32'h3000_0000 | (w << 2), 4'hF, $urandom);

    for (int n = 0; n < 30; n++) begin
      p = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0)
        do_oow(p, ($urandom_range(0, 1) == 0) ? (32'h3000_0100 | ($urandom_range(0, 63) << 2))
                                               : 32'h2000_0010);
      else
        do_txn(p, 1'(($urandom_range(0, 1))), 32'h3000_0000 | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3),
               4'($urandom_range(1, 15)), $urandom);
    end

    do_oow(0, 32'h3000_0100);

    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    tick_and_tie: begin
      tie_test();
    end

    do_txn(0, 1'b1, 32'h3000_0020, 4'hF, 32'h1122_3344);
    d = 32'hAABB_CCDD;
    drive(0, 1'b1, 1'b1, 4'h2, 32'h3000_0020, d);
    tick();
    check("drop_csb", ram_csb, 0);
    check("drop_wmask", ram_wmask, 4'h2);
    check("drop_web", ram_web, 0);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    check("drop_ack", wbs_a_ack_o, 0);
    check("drop_csb_after", ram_csb, 1);
    ref_write(6'd8, 4'h2, d);
    do_txn(1, 1'b0, 32'h3000_0020, 4'hF, 32'h0);

    drive(0, 1'b1, 1'b0, 4'hF, 32'h3000_000C, 32'h0);
    tick();
    tick();
    wb_rst_i = 1'b1;
    #1;
    check("rst_resp_ack", wbs_a_ack_o, 0);
    tick();
    check_reset_vals();
    wb_rst_i = 1'b0;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    do_txn(0, 1'b0, 32'h3000_000C, 4'hF, 32'h0);

    check("both_ack", both_ack_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
